// File: rtl/fixed_divide_seq.sv
`default_nettype none
// ============================================================================
// Module      : fixed_divide_seq
// Description : Iterative signed fixed-point divider, c = a / b, with all
//               operands and the result in the same Q format (operand_size
//               total bits, fractional_size fractional bits). Restoring
//               division, one quotient bit per clock, valid/ready on both
//               sides. Quotient is truncated toward zero and saturated on
//               range overflow; divide-by-zero returns a signed full-scale.
// Ports       : clk          system clock, rising edge
//               rst          synchronous active-high reset
//               in_valid     dividend/divisor present
//               in_ready     block can accept an operation (IDLE only)
//               a, b         signed dividend / divisor, QF
//               out_valid    result present (DONE only)
//               out_ready    consumer accepts result
//               c            signed quotient, QF
//               ovf          quotient saturated due to range overflow
//               div_by_zero  b was zero
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_divide_seq #(
   parameter int fractional_size = 12,
   parameter int operand_size    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [operand_size-1:0] a,
   input  logic [operand_size-1:0] b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [operand_size-1:0] c,
   output logic                    ovf,
   output logic                    div_by_zero
);

   localparam int c_w     = operand_size;
   localparam int c_f     = fractional_size;
   localparam int c_n     = c_w + c_f;                 // quotient bits / iterations
   localparam int c_cnt_w = $clog2(c_n + 1);           // counter must reach c_n

   localparam logic [c_cnt_w-1:0] c_cnt_end = (c_cnt_w)'(c_n);

   // Result range limits, expressed on the full-width quotient magnitude.
   localparam logic [c_n-1:0] c_neg_lim = (c_n)'(1) << (c_w - 1);   //  2^(W-1)
   localparam logic [c_n-1:0] c_pos_lim = c_neg_lim - (c_n)'(1);    //  2^(W-1)-1

   // Saturated output codes.
   localparam logic [c_w-1:0] c_min_neg = (c_w)'(1) << (c_w - 1);
   localparam logic [c_w-1:0] c_max_pos = ~c_min_neg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   state_t               state_q,   state_d;
   logic [c_cnt_w-1:0]   cnt_q,     cnt_d;
   // Dividend bits shift out of the top while quotient bits shift in at the
   // bottom; after c_n iterations the register holds the quotient magnitude.
   logic [c_n-1:0]       dq_q,      dq_d;
   // The remainder always ends below the divisor (<= 2^(W-1)), so W bits
   // hold it; only the shifted trial value needs W+1 bits.
   logic [c_w-1:0]       rem_q,     rem_d;
   logic [c_w-1:0]       div_q,     div_d;
   logic                 sign_q,    sign_d;
   logic                 a_neg_q,   a_neg_d;
   logic                 bzero_q,   bzero_d;
   logic [c_w-1:0]       c_q,       c_d;
   logic                 ovf_q,     ovf_d;
   logic                 dbz_q,     dbz_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [c_w-1:0]       a_mag;
   logic [c_w-1:0]       b_mag;
   logic [c_w:0]         rem_shift;
   logic [c_w-1:0]       rem_sub;
   logic                 q_bit;
   logic [c_w-1:0]       q_low;
   logic                 pos_ovf;
   logic                 neg_ovf;

   // Two's-complement magnitude; -2^(W-1) maps to 2^(W-1), which fits in
   // W unsigned bits.
   assign a_mag = a[c_w-1] ? (~a + (c_w)'(1)) : a;
   assign b_mag = b[c_w-1] ? (~b + (c_w)'(1)) : b;

   // One restoring step: bring in the next dividend bit, subtract the
   // divisor when it fits. The low W bits of the subtraction are exact
   // whenever the subtraction is kept.
   assign rem_shift = {rem_q, dq_q[c_n-1]};
   assign q_bit     = (rem_shift >= {1'b0, div_q});
   assign rem_sub   = rem_shift[c_w-1:0] - div_q;

   assign q_low   = dq_q[c_w-1:0];
   assign pos_ovf = (dq_q > c_pos_lim);
   assign neg_ovf = (dq_q > c_neg_lim);

   // ------------------------------------------------------------------------
   // Next-state / datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dq_d    = dq_q;
      rem_d   = rem_q;
      div_d   = div_q;
      sign_d  = sign_q;
      a_neg_d = a_neg_q;
      bzero_d = bzero_q;
      c_d     = c_q;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               dq_d    = (c_n)'(a_mag) << c_f;
               rem_d   = '0;
               div_d   = b_mag;
               sign_d  = a[c_w-1] ^ b[c_w-1];
               a_neg_d = a[c_w-1];
               bzero_d = (b == '0);
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end

         S_CALC: begin
            // Counter values 0..c_n-1 each perform one iteration; the
            // terminal count spends one cycle handing over to FIX so the
            // latency is the same fixed value for every operand.
            if (cnt_q == c_cnt_end) begin
               state_d = S_FIX;
            end else begin
               rem_d = q_bit ? rem_sub : rem_shift[c_w-1:0];
               dq_d  = (dq_q << 1) | (c_n)'(q_bit);
               cnt_d = cnt_q + (c_cnt_w)'(1);
            end
         end

         S_FIX: begin
            if (bzero_q) begin
               c_d   = a_neg_q ? c_min_neg : c_max_pos;
               ovf_d = 1'b0;
               dbz_d = 1'b1;
            end else if (!sign_q && pos_ovf) begin
               c_d   = c_max_pos;
               ovf_d = 1'b1;
               dbz_d = 1'b0;
            end else if (sign_q && neg_ovf) begin
               c_d   = c_min_neg;
               ovf_d = 1'b1;
               dbz_d = 1'b0;
            end else begin
               // Magnitude exactly 2^(W-1) negates onto itself, giving -2^(W-1).
               c_d   = sign_q ? (~q_low + (c_w)'(1)) : q_low;
               ovf_d = 1'b0;
               dbz_d = 1'b0;
            end
            state_d = S_DONE;
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dq_q    <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         sign_q  <= 1'b0;
         a_neg_q <= 1'b0;
         bzero_q <= 1'b0;
         c_q     <= '0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dq_q    <= dq_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         sign_q  <= sign_d;
         a_neg_q <= a_neg_d;
         bzero_q <= bzero_d;
         c_q     <= c_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign c           = c_q;
   assign ovf         = ovf_q;
   assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_divide_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fixed_divide_seq
// Description : Self-checking bench for fixed_divide_seq. A plain-arithmetic
//               reference model supplies expected results; one compare
//               process checks every cycle out_valid is high. Directed
//               vectors cover sign/truncation, saturation, divide-by-zero,
//               backpressure and reset mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_divide_seq;

   localparam int W   = 32;
   localparam int F   = 12;
   localparam int LAT = W + F + 2;
   localparam int NV  = 10;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] c;
   logic         ovf;
   logic         div_by_zero;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_c;
   logic         exp_ovf;
   logic         exp_dbz;

   fixed_divide_seq #(
      .fractional_size (F),
      .operand_size    (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .c           (c),
      .ovf         (ovf),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference model: returns {div_by_zero, ovf, c}.
   function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
      longint sa, sb, am, bm, q;
      bit     neg;
      if (bv == '0)
         return {1'b1, 1'b0, av[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF};
      sa  = longint'($signed(av));
      sb  = longint'($signed(bv));
      am  = (sa < 0) ? -sa : sa;
      bm  = (sb < 0) ? -sb : sb;
      q   = (am * 4096) / bm;
      neg = (sa < 0) != (sb < 0);
      if (!neg && q > 64'sd2147483647)
         return {1'b0, 1'b1, 32'h7FFF_FFFF};
      if (neg && q > 64'sd2147483648)
         return {1'b0, 1'b1, 32'h8000_0000};
      return {1'b0, 1'b0, neg ? 32'(-q) : 32'(q)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Compare process: every cycle the result is presented it must match the
   // model and the input side must be closed.
   always @(posedge clk) begin
      #1;
      if (out_valid === 1'b1) begin
         n_tests++;
         if (c !== exp_c || ovf !== exp_ovf || div_by_zero !== exp_dbz || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL result: got c=%h ovf=%b dbz=%b in_ready=%b, required c=%h ovf=%b dbz=%b in_ready=0",
                     c, ovf, div_by_zero, in_ready, exp_c, exp_ovf, exp_dbz);
         end
      end
   end

   // One complete operation: accept, latency check, optional backpressure
   // with noise on the input side, then handshake.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input int hold, input bit noise);
      int k;
      bit seen;
      bit ready_leak;
      k = 0;
      while (in_ready !== 1'b1 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("ready_before_op", 64'(in_ready), 64'd1);
      {exp_dbz, exp_ovf, exp_c} = model(ta, tbv);
      a = ta;
      b = tbv;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      seen = 1'b0;
      ready_leak = 1'b0;
      for (k = 1; k <= LAT + 10; k++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (in_ready !== 1'b0) ready_leak = 1'b1;
      end
      chk("latency", seen ? 64'(k) : 64'hFFFF, 64'(LAT));
      chk("in_ready_busy", 64'(ready_leak), 64'd0);
      if (!seen) return;
      for (int i = 0; i < hold; i++) begin
         if (noise) begin
            in_valid = i[0];
            a = $urandom;
            b = $urandom;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("valid_held", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("handshake_valid", 64'(out_valid), 64'd0);
      chk("handshake_ready", 64'(in_ready), 64'd1);
   endtask

   logic [W-1:0] va   [NV];
   logic [W-1:0] vb   [NV];
   logic [W+1:0] vexp [NV];
   int           vhold[NV];

   initial begin
      // {dbz, ovf, c} hand-computed
      va[0] = 32'd12288;     vb[0] = 32'd8192;      vexp[0] = {2'b00, 32'd6144};      vhold[0] = 0;
      va[1] = 32'hFFFF_F000; vb[1] = 32'd12288;     vexp[1] = {2'b00, 32'hFFFF_FAAB}; vhold[1] = 0;
      va[2] = 32'd4096;      vb[2] = 32'hFFFF_D000; vexp[2] = {2'b00, 32'hFFFF_FAAB}; vhold[2] = 0;
      va[3] = 32'hFFFF_F000; vb[3] = 32'hFFFF_D000; vexp[3] = {2'b00, 32'd1365};      vhold[3] = 0;
      va[4] = 32'h7FFF_FFFF; vb[4] = 32'd1;         vexp[4] = {2'b01, 32'h7FFF_FFFF}; vhold[4] = 0;
      va[5] = 32'h8000_0000; vb[5] = 32'hFFFF_F000; vexp[5] = {2'b01, 32'h7FFF_FFFF}; vhold[5] = 0;
      va[6] = 32'h8000_0000; vb[6] = 32'd4096;      vexp[6] = {2'b00, 32'h8000_0000}; vhold[6] = 0;
      va[7] = 32'd5000;      vb[7] = 32'd0;         vexp[7] = {2'b10, 32'h7FFF_FFFF}; vhold[7] = 0;
      va[8] = 32'hFFFF_FFFF; vb[8] = 32'd0;         vexp[8] = {2'b10, 32'h8000_0000}; vhold[8] = 0;
      va[9] = 32'd20480;     vb[9] = 32'd12288;     vexp[9] = {2'b00, 32'd6826};      vhold[9] = 10;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      exp_c     = '0;
      exp_ovf   = 1'b0;
      exp_dbz   = 1'b0;

      // Pin the model against hand-computed results.
      for (int i = 0; i < NV; i++)
         chk($sformatf("model_%0d", i), 64'(model(va[i], vb[i])), 64'(vexp[i]));

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  64'(in_ready),    64'd1);
      chk("rst_out_valid", 64'(out_valid),   64'd0);
      chk("rst_c",         64'(c),           64'd0);
      chk("rst_ovf",       64'(ovf),         64'd0);
      chk("rst_dbz",       64'(div_by_zero), 64'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++)
         run_op(va[i], vb[i], vhold[i], vhold[i] > 0);

      // Reset during the iteration phase discards the operation.
      a = 32'd40000;
      b = 32'd3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_out_valid", 64'(out_valid),   64'd0);
      chk("midrst_in_ready",  64'(in_ready),    64'd1);
      chk("midrst_c",         64'(c),           64'd0);
      chk("midrst_flags",     64'({ovf, div_by_zero}), 64'd0);
      begin
         bit leaked;
         leaked = 1'b0;
         for (int i = 0; i < LAT + 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) leaked = 1'b1;
         end
         chk("midrst_no_result", 64'(leaked), 64'd0);
      end
      chk("model_after_rst", 64'(model(32'd8192, 32'd4096)), 64'({2'b00, 32'd8192}));
      run_op(32'd8192, 32'd4096, 0, 1'b0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
